// File: rtl/interleaver_ping_pong_controller.sv
// Ping-pong buffer arbiter for a block interleaver: hands buffers to the writer,
// then presents full buffers to the read side in fill order and counts read bits.
module interleaver_ping_pong_controller #(
    parameter int unsigned ROW_NUMBER = 10,
    parameter int unsigned COL_NUMBER = 7
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WRITE_REQ,
    output logic        WRITE_GRANT,
    output logic        WRITE_BUFF_SEL,
    input  logic        WRITE_DONE,
    output logic        READ_START,
    output logic        PING_PONG_FLAG,
    input  logic        READ_ACK,
    input  logic        FIFO_WRITE,
    output logic [3:0]  BUFF_STATUS,
    output logic [15:0] FRAME_COUNT,
    output logic        PROTOCOL_ERR
);
    localparam int unsigned N  = ROW_NUMBER * COL_NUMBER;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {FREE = 2'b00, WRITING = 2'b01, FULL = 2'b10, READING = 2'b11} buf_state_e;
    typedef enum logic {W_IDLE, W_GRANTED} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY} rd_state_e;

    wr_state_e            wr_state_q, wr_state_d;
    rd_state_e            rd_state_q, rd_state_d;
    buf_state_e [1:0]     buf_q, buf_d;
    logic [1:0]           q_data_q, q_data_d;
    logic [1:0]           q_cnt_q, q_cnt_d;
    logic                 next_wr_q, next_wr_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 grant_q, grant_d;
    logic                 sel_q, sel_d;
    logic                 rs_q, rs_d;
    logic                 flag_q, flag_d;
    logic [15:0]          fc_q, fc_d;
    logic                 err_q, err_d;
    logic                 cand, cand_ok, push, pop;

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        buf_d      = buf_q;
        q_data_d   = q_data_q;
        q_cnt_d    = q_cnt_q;
        next_wr_d  = next_wr_q;
        bit_cnt_d  = bit_cnt_q;
        grant_d    = 1'b0;
        sel_d      = sel_q;
        rs_d       = rs_q;
        flag_d     = flag_q;
        fc_d       = fc_q;
        err_d      = err_q;
        push       = 1'b0;
        pop        = 1'b0;
        cand       = next_wr_q;
        cand_ok    = 1'b0;

        // Prefer the alternating pointer, fall back to whichever buffer is free
        if (buf_q[next_wr_q] == FREE) begin
            cand    = next_wr_q;
            cand_ok = 1'b1;
        end else if (buf_q[~next_wr_q] == FREE) begin
            cand    = ~next_wr_q;
            cand_ok = 1'b1;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (WRITE_DONE) err_d = 1'b1;
                if (WRITE_REQ && cand_ok) begin
                    wr_state_d  = W_GRANTED;
                    grant_d     = 1'b1;
                    sel_d       = cand;
                    buf_d[cand] = WRITING;
                    next_wr_d   = ~cand;
                end
            end
            W_GRANTED: begin
                if (WRITE_DONE) begin
                    buf_d[sel_q] = FULL;
                    push         = 1'b1;
                    wr_state_d   = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        case (rd_state_q)
            R_IDLE: begin
                if (q_cnt_q != 2'd0 && buf_q[q_data_q[0]] == FULL) begin
                    rd_state_d = R_START;
                    rs_d       = 1'b1;
                    flag_d     = q_data_q[0];
                end
            end
            R_START: begin
                if (READ_ACK) begin
                    pop           = 1'b1;
                    buf_d[flag_q] = READING;
                    bit_cnt_d     = '0;
                    rd_state_d    = R_BUSY;
                    rs_d          = 1'b0;
                end
            end
            R_BUSY: begin
                if (FIFO_WRITE) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        buf_d[flag_q] = FREE;
                        fc_d          = fc_q + 16'd1;
                        rd_state_d    = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        if (READ_ACK && rd_state_q != R_START) err_d = 1'b1;
        if (FIFO_WRITE && rd_state_q != R_BUSY) err_d = 1'b1;

        // Pop before push so a same-cycle pop/push keeps fill order
        if (pop) begin
            q_data_d[0] = q_data_q[1];
            q_cnt_d     = q_cnt_d - 2'd1;
        end
        if (push) begin
            q_data_d[q_cnt_d[0]] = sel_q;
            q_cnt_d              = q_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            buf_q      <= {FREE, FREE};
            q_data_q   <= 2'b00;
            q_cnt_q    <= 2'd0;
            next_wr_q  <= 1'b0;
            bit_cnt_q  <= '0;
            grant_q    <= 1'b0;
            sel_q      <= 1'b0;
            rs_q       <= 1'b0;
            flag_q     <= 1'b0;
            fc_q       <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            buf_q      <= buf_d;
            q_data_q   <= q_data_d;
            q_cnt_q    <= q_cnt_d;
            next_wr_q  <= next_wr_d;
            bit_cnt_q  <= bit_cnt_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            rs_q       <= rs_d;
            flag_q     <= flag_d;
            fc_q       <= fc_d;
            err_q      <= err_d;
        end
    end

    assign WRITE_GRANT    = grant_q;
    assign WRITE_BUFF_SEL = sel_q;
    assign READ_START     = rs_q;
    assign PING_PONG_FLAG = flag_q;
    assign BUFF_STATUS    = {buf_q[1], buf_q[0]};
    assign FRAME_COUNT    = fc_q;
    assign PROTOCOL_ERR   = err_q;

endmodule

// File: tb/tb_interleaver_ping_pong_controller.sv
// Bench for the interleaver ping-pong controller: directed scenarios with random
// timing, plus random legal traffic compared against a frame-level reference model.
module tb_interleaver_ping_pong_controller;
    localparam int ROWS = 10;
    localparam int COLS = 7;
    localparam int N = ROWS * COLS;
    localparam logic [1:0] FREE = 2'b00, WRITING = 2'b01, FULL = 2'b10, READING = 2'b11;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        WRITE_REQ = 1'b0, WRITE_DONE = 1'b0, READ_ACK = 1'b0, FIFO_WRITE = 1'b0;
    logic        WRITE_GRANT, WRITE_BUFF_SEL, READ_START, PING_PONG_FLAG, PROTOCOL_ERR;
    logic [3:0]  BUFF_STATUS;
    logic [15:0] FRAME_COUNT;

    int n_checks = 0;
    int n_fail = 0;

    interleaver_ping_pong_controller #(
        .ROW_NUMBER(ROWS),
        .COL_NUMBER(COLS)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .WRITE_REQ     (WRITE_REQ),
        .WRITE_GRANT   (WRITE_GRANT),
        .WRITE_BUFF_SEL(WRITE_BUFF_SEL),
        .WRITE_DONE    (WRITE_DONE),
        .READ_START    (READ_START),
        .PING_PONG_FLAG(PING_PONG_FLAG),
        .READ_ACK      (READ_ACK),
        .FIFO_WRITE    (FIFO_WRITE),
        .BUFF_STATUS   (BUFF_STATUS),
        .FRAME_COUNT   (FRAME_COUNT),
        .PROTOCOL_ERR  (PROTOCOL_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: frame-level view of two buffers and a FIFO of full buffer indices
    logic [1:0]  m_buf [2];
    int          m_q [$];
    bit          m_wgr, m_sel, m_nxt, m_flag, m_rs, m_grant, m_err;
    int          m_rd;      // 0 waiting, 1 offered, 2 streaming
    int          m_bits;
    logic [15:0] m_frames;

    task automatic model_reset();
        m_buf[0] = FREE; m_buf[1] = FREE; m_q.delete();
        m_wgr = 0; m_sel = 0; m_nxt = 0; m_flag = 0; m_rs = 0; m_grant = 0; m_err = 0;
        m_rd = 0; m_bits = 0; m_frames = 16'd0;
    endtask

    task automatic model_step(input bit req, input bit done, input bit ack, input bit fw);
        logic [1:0] pre [2];
        int rd0;
        int pick;
        pre = m_buf;
        rd0 = m_rd;
        m_grant = 0;
        if (ack && rd0 != 1) m_err = 1;
        if (fw && rd0 != 2) m_err = 1;
        if (rd0 == 0) begin
            if (m_q.size() > 0 && pre[m_q[0]] == FULL) begin
                m_rd = 1; m_rs = 1; m_flag = m_q[0][0];
            end
        end else if (rd0 == 1) begin
            if (ack) begin
                void'(m_q.pop_front());
                m_buf[m_flag] = READING; m_bits = 0; m_rd = 2; m_rs = 0;
            end
        end else if (fw) begin
            m_bits++;
            if (m_bits == N) begin
                m_buf[m_flag] = FREE; m_frames = m_frames + 16'd1; m_rd = 0;
            end
        end
        if (!m_wgr) begin
            if (done) m_err = 1;
            if (req) begin
                pick = -1;
                if (pre[m_nxt] == FREE) pick = int'(m_nxt);
                else if (pre[1 - int'(m_nxt)] == FREE) pick = 1 - int'(m_nxt);
                if (pick >= 0) begin
                    m_buf[pick] = WRITING; m_sel = pick[0]; m_nxt = ~pick[0];
                    m_wgr = 1; m_grant = 1;
                end
            end
        end else if (done) begin
            m_buf[m_sel] = FULL; m_q.push_back(int'(m_sel)); m_wgr = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        WRITE_REQ = 0; WRITE_DONE = 0; READ_ACK = 0; FIFO_WRITE = 0;
        RESET = 0;
        tick();
        tick();
        RESET = 1;
    endtask

    task automatic pulse_done();
        WRITE_DONE = 1; tick(); WRITE_DONE = 0;
    endtask

    task automatic req_once();
        WRITE_REQ = 1; tick(); WRITE_REQ = 0;
    endtask

    task automatic ack_once();
        READ_ACK = 1; tick(); READ_ACK = 0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            FIFO_WRITE = 1; tick(); FIFO_WRITE = 0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_reset();
        logic [24:0] outs;
        #2 RESET = 0;
        #1;
        outs = {WRITE_GRANT, WRITE_BUFF_SEL, READ_START, PING_PONG_FLAG, BUFF_STATUS,
                FRAME_COUNT, PROTOCOL_ERR};
        n_checks++;
        if (outs !== 25'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        WRITE_REQ = 1; WRITE_DONE = 1; READ_ACK = 1; FIFO_WRITE = 1;
        tick();
        outs = {WRITE_GRANT, WRITE_BUFF_SEL, READ_START, PING_PONG_FLAG, BUFF_STATUS,
                FRAME_COUNT, PROTOCOL_ERR};
        n_checks++;
        if (outs !== 25'd0) begin
            n_fail++; $display("FAIL reset_held_outputs got=%h exp=0", outs);
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        do_reset();
        req_once();
        n_checks++;
        if ({WRITE_GRANT, WRITE_BUFF_SEL, BUFF_STATUS} !== {1'b1, 1'b0, 4'b0001}) begin
            n_fail++; $display("FAIL single_grant got=%b%b_%b exp=10_0001",
                               WRITE_GRANT, WRITE_BUFF_SEL, BUFF_STATUS);
        end
        tick();
        n_checks++;
        if (WRITE_GRANT !== 1'b0) begin
            n_fail++; $display("FAIL single_grant_pulse got=%b exp=0", WRITE_GRANT);
        end
        repeat ($urandom_range(0, 3)) tick();
        pulse_done();
        n_checks++;
        if ({BUFF_STATUS, READ_START} !== {4'b0010, 1'b0}) begin
            n_fail++; $display("FAIL single_full got=%b rs=%b exp=0010 rs=0", BUFF_STATUS, READ_START);
        end
        tick();
        n_checks++;
        if ({READ_START, PING_PONG_FLAG} !== 2'b10) begin
            n_fail++; $display("FAIL single_read_start got=%b%b exp=10", READ_START, PING_PONG_FLAG);
        end
        repeat ($urandom_range(1, 4)) tick();
        n_checks++;
        if ({READ_START, PING_PONG_FLAG} !== 2'b10) begin
            n_fail++; $display("FAIL single_read_hold got=%b%b exp=10", READ_START, PING_PONG_FLAG);
        end
        ack_once();
        n_checks++;
        if ({BUFF_STATUS, READ_START} !== {4'b0011, 1'b0}) begin
            n_fail++; $display("FAIL single_reading got=%b rs=%b exp=0011 rs=0", BUFF_STATUS, READ_START);
        end
        stream(N - 1);
        n_checks++;
        if ({BUFF_STATUS, FRAME_COUNT} !== {4'b0011, 16'd0}) begin
            n_fail++; $display("FAIL single_before_last got=%b fc=%0d exp=0011 fc=0", BUFF_STATUS, FRAME_COUNT);
        end
        FIFO_WRITE = 1; tick(); FIFO_WRITE = 0;
        n_checks++;
        if ({BUFF_STATUS, FRAME_COUNT, PROTOCOL_ERR} !== {4'b0000, 16'd1, 1'b0}) begin
            n_fail++; $display("FAIL single_done got=%b fc=%0d err=%b exp=0000 fc=1 err=0",
                               BUFF_STATUS, FRAME_COUNT, PROTOCOL_ERR);
        end
    endtask

    task automatic test_both_full();
        do_reset();
        req_once();
        pulse_done();
        req_once();
        n_checks++;
        if ({WRITE_GRANT, WRITE_BUFF_SEL} !== 2'b11) begin
            n_fail++; $display("FAIL full_second_sel got=%b%b exp=11", WRITE_GRANT, WRITE_BUFF_SEL);
        end
        pulse_done();
        n_checks++;
        if (BUFF_STATUS !== 4'b1010) begin
            n_fail++; $display("FAIL full_status got=%b exp=1010", BUFF_STATUS);
        end
        WRITE_REQ = 1;
        repeat ($urandom_range(3, 6)) begin
            tick();
            n_checks++;
            if (WRITE_GRANT !== 1'b0) begin
                n_fail++; $display("FAIL full_blocked got=%b exp=0", WRITE_GRANT);
            end
        end
        n_checks++;
        if ({READ_START, PING_PONG_FLAG} !== 2'b10) begin
            n_fail++; $display("FAIL full_first_read got=%b%b exp=10", READ_START, PING_PONG_FLAG);
        end
        ack_once();
        stream(N - 1);
        FIFO_WRITE = 1; tick(); FIFO_WRITE = 0;
        n_checks++;
        if ({WRITE_GRANT, BUFF_STATUS, FRAME_COUNT} !== {1'b0, 4'b1000, 16'd1}) begin
            n_fail++; $display("FAIL full_freed got=%b_%b fc=%0d exp=0_1000 fc=1",
                               WRITE_GRANT, BUFF_STATUS, FRAME_COUNT);
        end
        tick();
        WRITE_REQ = 0;
        n_checks++;
        if ({WRITE_GRANT, WRITE_BUFF_SEL, BUFF_STATUS, READ_START, PING_PONG_FLAG} !==
            {1'b1, 1'b0, 4'b1001, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL full_regrant got=%b%b_%b_%b%b exp=10_1001_11", WRITE_GRANT,
                               WRITE_BUFF_SEL, BUFF_STATUS, READ_START, PING_PONG_FLAG);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_once();
        pulse_done();
        tick();
        ack_once();
        req_once();
        n_checks++;
        if ({WRITE_BUFF_SEL, BUFF_STATUS} !== {1'b1, 4'b0111}) begin
            n_fail++; $display("FAIL simul_setup got=%b_%b exp=1_0111", WRITE_BUFF_SEL, BUFF_STATUS);
        end
        stream(N - 1);
        WRITE_DONE = 1; FIFO_WRITE = 1; tick(); WRITE_DONE = 0; FIFO_WRITE = 0;
        n_checks++;
        if ({BUFF_STATUS, FRAME_COUNT, PROTOCOL_ERR} !== {4'b1000, 16'd1, 1'b0}) begin
            n_fail++; $display("FAIL simul_both got=%b fc=%0d err=%b exp=1000 fc=1 err=0",
                               BUFF_STATUS, FRAME_COUNT, PROTOCOL_ERR);
        end
        tick();
        n_checks++;
        if ({READ_START, PING_PONG_FLAG} !== 2'b11) begin
            n_fail++; $display("FAIL simul_next_read got=%b%b exp=11", READ_START, PING_PONG_FLAG);
        end
    endtask

    task automatic test_protocol_err();
        logic [24:0] outs;
        do_reset();
        ack_once();
        repeat ($urandom_range(2, 5)) tick();
        n_checks++;
        if ({PROTOCOL_ERR, READ_START, BUFF_STATUS} !== {1'b1, 1'b0, 4'b0000}) begin
            n_fail++; $display("FAIL err_stray_ack got=%b%b_%b exp=10_0000",
                               PROTOCOL_ERR, READ_START, BUFF_STATUS);
        end
        do_reset();
        n_checks++;
        if (PROTOCOL_ERR !== 1'b0) begin
            n_fail++; $display("FAIL err_cleared got=%b exp=0", PROTOCOL_ERR);
        end
        FIFO_WRITE = 1; tick(); FIFO_WRITE = 0;
        n_checks++;
        if ({PROTOCOL_ERR, FRAME_COUNT} !== {1'b1, 16'd0}) begin
            n_fail++; $display("FAIL err_stray_fifo got=%b fc=%0d exp=1 fc=0", PROTOCOL_ERR, FRAME_COUNT);
        end
        do_reset();
        pulse_done();
        n_checks++;
        if ({PROTOCOL_ERR, BUFF_STATUS} !== {1'b1, 4'b0000}) begin
            n_fail++; $display("FAIL err_stray_done got=%b_%b exp=1_0000", PROTOCOL_ERR, BUFF_STATUS);
        end
        do_reset();
        req_once();
        pulse_done();
        tick();
        ack_once();
        stream($urandom_range(5, 30));
        @(negedge CLK);
        RESET = 0;
        #1;
        outs = {WRITE_GRANT, WRITE_BUFF_SEL, READ_START, PING_PONG_FLAG, BUFF_STATUS,
                FRAME_COUNT, PROTOCOL_ERR};
        n_checks++;
        if (outs !== 25'd0) begin
            n_fail++; $display("FAIL err_async_reset got=%h exp=0", outs);
        end
        tick();
        RESET = 1;
        req_once();
        n_checks++;
        if ({WRITE_GRANT, WRITE_BUFF_SEL, BUFF_STATUS} !== {1'b1, 1'b0, 4'b0001}) begin
            n_fail++; $display("FAIL err_post_reset_grant got=%b%b_%b exp=10_0001",
                               WRITE_GRANT, WRITE_BUFF_SEL, BUFF_STATUS);
        end
    endtask

    task automatic test_random();
        bit req, done, ack, fw;
        logic [24:0] got, exp;
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            req  = !m_wgr && ($urandom_range(0, 2) != 0);
            done = m_wgr && ($urandom_range(0, 3) == 0);
            ack  = (m_rd == 1) && ($urandom_range(0, 2) == 0);
            fw   = (m_rd == 2) && ($urandom_range(0, 3) != 0);
            WRITE_REQ = req; WRITE_DONE = done; READ_ACK = ack; FIFO_WRITE = fw;
            tick();
            model_step(req, done, ack, fw);
            got = {WRITE_GRANT, WRITE_BUFF_SEL, READ_START, PING_PONG_FLAG, BUFF_STATUS,
                   FRAME_COUNT, PROTOCOL_ERR};
            exp = {m_grant, m_sel, m_rs, m_flag, m_buf[1], m_buf[0], m_frames, m_err};
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL random_cycle_%0d got=%h exp=%h", c, got, exp);
            end
        end
        WRITE_REQ = 0; WRITE_DONE = 0; READ_ACK = 0; FIFO_WRITE = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_both_full();
        test_simultaneous();
        test_protocol_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interleaver_ping_pong_controller.md
INTERLEAVER_PING_PONG_CONTROLLER -- requirements
Module: interleaver_ping_pong_controller

Interface
REQ-001 SHALL have parameter ROW_NUMBER, default 10, interleaver matrix rows.
REQ-002 SHALL have parameter COL_NUMBER, default 7, interleaver matrix columns.
REQ-003 SHALL define N = ROW_NUMBER*COL_NUMBER; CW = $clog2(N+1).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 WRITE_REQ  in  1  writer requests a buffer to fill (level).
REQ-007 WRITE_GRANT  out  1  one-cycle pulse: buffer granted to writer.
REQ-008 WRITE_BUFF_SEL  out  1  buffer index granted; valid from WRITE_GRANT until WRITE_DONE.
REQ-009 WRITE_DONE  in  1  one-cycle pulse: granted buffer completely written.
REQ-010 READ_START  out  1  level: full buffer ready for read-buffer block.
REQ-011 PING_PONG_FLAG  out  1  buffer index to read; stable whenever READ_START is high.
REQ-012 READ_ACK  in  1  one-cycle pulse from read-buffer block.
REQ-013 FIFO_WRITE  in  1  monitored read-side output-FIFO write strobe; one per bit read.
REQ-014 BUFF_STATUS  out  4  {buf1[1:0], buf0[1:0]}: 00 FREE, 01 WRITING, 10 FULL, 11 READING.
REQ-015 FRAME_COUNT  out  16  count of completely read frames, wraps 0xFFFF->0.
REQ-016 PROTOCOL_ERR  out  1  sticky protocol-violation flag.

Function
REQ-017 SHALL keep a 2-bit state per buffer; all outputs registered.
REQ-018 Write FSM SHALL have states W_IDLE, W_GRANTED.
REQ-019 In W_IDLE with WRITE_REQ=1 and at least one FREE buffer, SHALL go W_GRANTED, pulse WRITE_GRANT one cycle, set WRITE_BUFF_SEL, mark that buffer WRITING.
REQ-020 Buffer selection SHALL alternate: pick next_wr pointer if FREE, else the other FREE buffer; next_wr = selected^1 after grant.
REQ-021 In W_IDLE with WRITE_REQ=1 and no FREE buffer, SHALL remain W_IDLE, no grant.
REQ-022 In W_GRANTED, WRITE_DONE=1 SHALL mark WRITE_BUFF_SEL buffer FULL, push its index to a 2-entry read order queue, return to W_IDLE.
REQ-023 WRITE_DONE in W_IDLE SHALL be ignored except setting PROTOCOL_ERR.
REQ-024 Read FSM SHALL have states R_IDLE, R_START, R_BUSY.
REQ-025 In R_IDLE with read order queue non-empty (head buffer FULL), SHALL go R_START, READ_START=1, PING_PONG_FLAG=head index.
REQ-026 In R_START, READ_START and PING_PONG_FLAG SHALL hold until READ_ACK=1; then pop queue, mark buffer READING, clear bit counter, go R_BUSY, READ_START=0 next cycle.
REQ-027 In R_BUSY, each FIFO_WRITE=1 SHALL increment the CW-bit bit counter; FIFO_WRITE with counter==N-1 SHALL mark buffer FREE, increment FRAME_COUNT, go R_IDLE.
REQ-028 READ_ACK outside R_START, or FIFO_WRITE outside R_BUSY, SHALL be ignored and set PROTOCOL_ERR.
REQ-029 Latency: WRITE_DONE sampled at edge k -> buffer FULL after edge k -> READ_START high after edge k+1 when R_IDLE.
REQ-030 Decisions SHALL use pre-edge registered state: buffer freed at edge k is grantable at edge k+1, not k.
REQ-031 Simultaneous WRITE_DONE and final FIFO_WRITE SHALL both take effect in the same cycle on their respective buffers.
REQ-032 Both buffers FULL SHALL block writer (WRITE_GRANT stays 0) until one frame fully read.
REQ-033 PROTOCOL_ERR SHALL clear only on reset.

Reset
REQ-034 RESET=0 SHALL immediately force W_IDLE, R_IDLE, both buffers FREE, queue empty, next_wr=0, counter=0.
REQ-035 During reset all outputs SHALL be 0 (BUFF_STATUS=0000, FRAME_COUNT=0).
REQ-036 Reset assertion mid-frame SHALL abandon all frames; after release first grant SHALL select buffer 0.

Verification
REQ-037 Reset, WRITE_REQ=1 -> WRITE_GRANT pulse, WRITE_BUFF_SEL=0, BUFF_STATUS=0001.
REQ-038 WRITE_DONE pulse -> BUFF_STATUS=0010, READ_START=1 PING_PONG_FLAG=0 two edges later; READ_ACK -> 0011; 70 FIFO_WRITE -> 0000, FRAME_COUNT=1.
REQ-039 Two frames written with no reads -> BUFF_STATUS=1010, third WRITE_REQ ungranted; first read completes -> grant on buffer 0 one cycle after FREE.
REQ-040 Order: write buf0, buf1 full -> reads issued PING_PONG_FLAG=0 then 1.
REQ-041 WRITE_DONE and 70th FIFO_WRITE same cycle -> both buffer state changes visible next cycle, no error.
REQ-042 Stray READ_ACK in R_IDLE -> PROTOCOL_ERR=1 held; RESET=0 mid R_BUSY -> all outputs 0 asynchronously.
